clock_set_ctrl: RTL

Time-set controller for the HH:MM:SS digital clock. It sequences the three 2-digit BCD counters (hours mod-24, minutes mod-60, seconds mod-60) between run mode and a per-field edit mode driven by debounced buttons. In edit mode it holds each counter in preset with controller-owned BCD values, and releases them on exit so counting resumes from the edited time.

---
 rtl/clock_set_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set controller for an HH:MM:SS BCD clock: sequences run mode and per-field
// edit modes, owning the counter preset values while editing.
module clock_set_ctrl #(
    parameter int HR_MOD  = 24,
    parameter int MS_MOD  = 60,
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [7:0] hr_q,
    input  logic [7:0] min_q,
    input  logic [7:0] sec_q,
    output logic       preset_hr,
    output logic       preset_min,
    output logic       preset_sec,
    output logic [7:0] q0_hr,
    output logic [7:0] q0_min,
    output logic [7:0] q0_sec,
    output logic [2:0] sel,
    output logic       run_en
);

    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} state_t;

    localparam logic [7:0] HR_MAX = {4'((HR_MOD - 1) / 10), 4'((HR_MOD - 1) % 10)};
    localparam logic [7:0] MS_MAX = {4'((MS_MOD - 1) / 10), 4'((MS_MOD - 1) % 10)};
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Captured live values may be garbage (non-BCD digit or out of range).
    function automatic logic [7:0] sanitize(input logic [7:0] v, input int m);
        int n;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || n >= m) return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max);
        if (up) begin
            if (v == max)         return 8'h00;
            if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
            return {v[7:4], v[3:0] + 4'd1};
        end
        if (v == 8'h00)           return max;
        if (v[3:0] == 4'd0)       return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    state_t     state, state_nx;
    logic [7:0] ed_hr, ed_min, ed_sec;
    logic [7:0] tmo_cnt;
    logic       preset;
    logic [2:0] sel_nx;
    logic       any_btn, step_en;

    assign any_btn = mode_btn | inc_btn | dec_btn;
    assign step_en = (state != RUN) && !mode_btn && (inc_btn ^ dec_btn);

    // Timeout only fires on a tick with no button in the same cycle.
    always_comb begin
        state_nx = state;
        if (mode_btn)
            state_nx = state_t'(state + 2'd1);
        else if (state != RUN && tick_1hz && !any_btn && tmo_cnt == TO_LAST)
            state_nx = RUN;
    end

    always_comb begin
        sel_nx = 3'b000;
        case (state_nx)
            SET_HR:  sel_nx = 3'b100;
            SET_MIN: sel_nx = 3'b010;
            SET_SEC: sel_nx = 3'b001;
            default: sel_nx = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            ed_hr   <= 8'h00;
            ed_min  <= 8'h00;
            ed_sec  <= 8'h00;
            tmo_cnt <= 8'd0;
            sel     <= 3'b000;
            preset  <= 1'b1;
            run_en  <= 1'b0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            preset <= (state_nx != RUN);
            run_en <= (state_nx == RUN);

            if (state == RUN || state_nx == RUN || any_btn)
                tmo_cnt <= 8'd0;
            else if (tick_1hz)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (state == RUN && mode_btn) begin
                ed_hr  <= sanitize(hr_q, HR_MOD);
                ed_min <= sanitize(min_q, MS_MOD);
                ed_sec <= sanitize(sec_q, MS_MOD);
            end else if (step_en) begin
                case (state)
                    SET_HR:  ed_hr  <= bcd_step(ed_hr, inc_btn, HR_MAX);
                    SET_MIN: ed_min <= bcd_step(ed_min, inc_btn, MS_MAX);
                    SET_SEC: ed_sec <= bcd_step(ed_sec, inc_btn, MS_MAX);
                    default: ;
                endcase
            end
        end
    end

    assign preset_hr  = preset;
    assign preset_min = preset;
    assign preset_sec = preset;
    assign q0_hr      = ed_hr;
    assign q0_min     = ed_min;
    assign q0_sec     = ed_sec;

endmodule
